// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the AES-256 CTR sequencer
package aes_pkg;

  localparam int NR  = 14;
  localparam int NRK = NR + 1;

  typedef logic [127:0] block_t;
  typedef logic [255:0] key_t;

  typedef enum logic [2:0] {
    IDLE,
    KEXP,
    READY,
    ENC,
    OUT
  } state_t;

endpackage

// File: rtl/aes_rk_store.sv
// rtl/aes_rk_store.sv - NRK x 128 round-key register file, combinational read, zero beyond rkNR
module aes_rk_store
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [3:0]   widx,
  input  logic [127:0] wdata,
  input  logic [3:0]   ridx,
  output logic [127:0] rdata
);

  block_t mem [NRK];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NRK; i++) mem[i] <= '0;
    end else if (we && (widx < 4'(NRK))) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = (ridx < 4'(NRK)) ? mem[ridx] : '0;

endmodule

// File: rtl/aes_ctr_ctrl.sv
// rtl/aes_ctr_ctrl.sv - AES-256 CTR-mode sequencer: round-key capture, counter issue, keystream XOR.
// Optional AES_CTR_WRAP_STOP_EN: refuse new input after a counter wrap until the next iv_load.
module aes_ctr_ctrl
  import aes_pkg::*;
#(
  parameter int CTR_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [255:0] key,
  input  logic         iv_load,
  input  logic [127:0] iv,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic [127:0] din,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic [127:0] dout,
  output logic         ke_start,
  output logic [255:0] ke_key,
  input  logic         ke_rk_valid,
  input  logic [127:0] ke_rk,
  output logic         core_start,
  output logic [127:0] core_block,
  input  logic         core_done,
  input  logic [127:0] core_ks,
  input  logic [3:0]   core_rk_idx,
  output logic [127:0] core_rk,
  output logic         key_ready,
  output logic         busy,
  output logic         ctr_wrap
);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       iv_ok;
  block_t     ctr_q, din_q;

  logic idle_ready, take_key, take_iv, take_din;
  logic rk_beat, rk_last, take_ks, take_out;

  assign idle_ready = (state == IDLE) || (state == READY);
  assign take_key   = idle_ready && key_load;
  assign take_iv    = idle_ready && iv_load;
  assign take_din   = din_valid && din_ready;
  assign rk_beat    = (state == KEXP) && ke_rk_valid;
  assign rk_last    = rk_beat && (cnt == 4'(NR));
  assign take_ks    = (state == ENC) && core_done;
  assign take_out   = (state == OUT) && dout_ready;
  assign busy       = !idle_ready;

  // Host key/IV updates take priority over a data block offered in the same cycle.
`ifdef AES_CTR_WRAP_STOP_EN
  assign din_ready = (state == READY) && key_ready && iv_ok && !key_load && !iv_load && !ctr_wrap;
`else
  assign din_ready = (state == READY) && key_ready && iv_ok && !key_load && !iv_load;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (key_load) state_nxt = KEXP;
      KEXP:    if (rk_last) state_nxt = READY;
      READY: begin
        if (key_load)      state_nxt = KEXP;
        else if (take_din) state_nxt = ENC;
      end
      ENC:     if (core_done) state_nxt = OUT;
      OUT:     if (dout_ready) state_nxt = READY;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ke_key     <= '0;
      ke_start   <= 1'b0;
      core_start <= 1'b0;
      core_block <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      key_ready  <= 1'b0;
      ctr_wrap   <= 1'b0;
      ctr_q      <= '0;
      din_q      <= '0;
      cnt        <= '0;
      iv_ok      <= 1'b0;
    end else begin
      ke_start   <= 1'b0;
      core_start <= 1'b0;
      if (take_key) begin
        ke_key    <= key;
        ke_start  <= 1'b1;
        key_ready <= 1'b0;
        cnt       <= '0;
      end
      if (rk_beat) begin
        cnt <= cnt + 4'd1;
        if (rk_last) key_ready <= 1'b1;
      end
      if (take_iv) begin
        ctr_q    <= iv;
        iv_ok    <= 1'b1;
        ctr_wrap <= 1'b0;
      end
      if (take_din) begin
        din_q      <= din;
        core_start <= 1'b1;
        core_block <= ctr_q;
      end
      if (take_ks) begin
        dout       <= din_q ^ core_ks;
        dout_valid <= 1'b1;
      end
      // Only the low CTR_W bits count; the nonce part of the block never changes.
      if (take_out) begin
        dout_valid         <= 1'b0;
        ctr_q[CTR_W-1:0]   <= ctr_q[CTR_W-1:0] + CTR_W'(1);
        if (&ctr_q[CTR_W-1:0]) ctr_wrap <= 1'b1;
      end
    end
  end

  aes_rk_store u_rk_store (
    .clk   (clk),
    .rst   (rst),
    .we    (rk_beat),
    .widx  (cnt),
    .wdata (ke_rk),
    .ridx  (core_rk_idx),
    .rdata (core_rk)
  );

endmodule
